// File: rtl/servo_frame_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// servo_frame_scheduler_pkg
//   Shared definitions for the servo frame scheduler: FSM state encoding,
//   counter widths, default timing constants and the pulse-length clamp.
// -----------------------------------------------------------------------------
package servo_frame_scheduler_pkg;

    localparam int MAX_CHANNELS = 8;    // upd_chan / active_chan are 3 bits
    localparam int LEN_W        = 16;   // per-pulse µs counter and lengths
    localparam int FRAME_CNT_W  = 15;   // frame µs counter

    localparam int DEF_FRAME_US   = 20000;
    localparam int DEF_MIN_US     = 1000;
    localparam int DEF_MAX_US     = 2000;
    localparam int DEF_DEFAULT_US = 1500;

    typedef enum logic [1:0] {
        ST_LATCH = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    typedef logic [LEN_W-1:0] len_t;

    function automatic len_t clamp_len(input len_t value, input len_t lo, input len_t hi);
        if (value < lo) return lo;
        if (value > hi) return hi;
        return value;
    endfunction

endpackage

// File: rtl/servo_frame_scheduler_us_tick_gen.sv
// -----------------------------------------------------------------------------
// us_tick_gen
//   Microsecond tick prescaler counting 0..CLK_MHZ-1.
//   Ports:
//     CLK     in   system clock
//     RST_N   in   synchronous reset, active low
//     restart in   treat the counter as 0 in this cycle (re-phase the µs grid)
//     tick    out  high in the last cycle of each µs
// -----------------------------------------------------------------------------
module us_tick_gen #(
    parameter int CLK_MHZ = 100
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_MHZ - 1);

    if (CLK_MHZ < 1) begin : g_bad_clk
        $error("us_tick_gen: CLK_MHZ must be at least 1");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_eff;

    // Restart acts in the same cycle, so the cycle carrying restart is µs
    // cycle 0 and the next tick lands exactly CLK_MHZ cycles after it.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        cnt_eff = restart ? '0 : cnt_q;
        tick    = (cnt_eff == LAST);
        cnt_d   = tick ? '0 : cnt_eff + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!RST_N) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/servo_frame_scheduler.sv
// -----------------------------------------------------------------------------
// servo_frame_scheduler
//   Time-multiplexes one FRAME_US servo frame across CHANNELS outputs,
//   RC-PPM style: channel pulses run back-to-back from the frame boundary,
//   then all outputs idle low until the frame ends. Position updates land in
//   shadow registers and are copied to the active set only at frame start.
//   Ports:
//     CLK, RST_N    clock; synchronous active-low reset
//     upd_valid/ready, upd_chan, upd_len   position update handshake (µs)
//     CONTROL_PINS  servo outputs, bit i drives servo i
//     frame_start   one-cycle strobe at every frame boundary
//     active_chan   channel currently pulsing (0 while idle)
// -----------------------------------------------------------------------------
module servo_frame_scheduler
    import servo_frame_scheduler_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int CLK_MHZ    = 100,
    parameter int FRAME_US   = DEF_FRAME_US,
    parameter int MIN_US     = DEF_MIN_US,
    parameter int MAX_US     = DEF_MAX_US,
    parameter int DEFAULT_US = DEF_DEFAULT_US
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                upd_valid,
    output logic                upd_ready,
    input  logic [2:0]          upd_chan,
    input  logic [15:0]         upd_len,
    output logic [CHANNELS-1:0] CONTROL_PINS,
    output logic                frame_start,
    output logic [2:0]          active_chan
);

    if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
        $error("servo_frame_scheduler: CHANNELS must be 1..8");
    end
    if (MIN_US < 1 || MIN_US > MAX_US || MAX_US >= (1 << LEN_W)) begin : g_bad_limits
        $error("servo_frame_scheduler: need 1 <= MIN_US <= MAX_US < 65536");
    end
    if (DEFAULT_US < MIN_US || DEFAULT_US > MAX_US) begin : g_bad_default
        $error("servo_frame_scheduler: DEFAULT_US outside [MIN_US, MAX_US]");
    end
    if (CHANNELS * MAX_US >= FRAME_US || FRAME_US >= (1 << FRAME_CNT_W)) begin : g_bad_frame
        $error("servo_frame_scheduler: pulses do not fit the frame or FRAME_US too large");
    end

    localparam len_t                   MIN_LEN   = len_t'(MIN_US);
    localparam len_t                   MAX_LEN   = len_t'(MAX_US);
    localparam len_t                   DEF_LEN   = len_t'(DEFAULT_US);
    localparam logic [FRAME_CNT_W-1:0] FRAME_END = FRAME_CNT_W'(FRAME_US);
    localparam logic [2:0]             LAST_CH   = 3'(CHANNELS - 1);
    localparam logic [3:0]             NUM_CH    = 4'(CHANNELS);

    state_e                 state_q, state_d;
    logic [2:0]             chan_q, chan_d, chan_eff;
    len_t                   pulse_cnt_q, pulse_cnt_d, pulse_cnt_eff;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d, frame_cnt_eff;
    len_t                   cur_len;
    len_t                   shadow_q [MAX_CHANNELS];
    len_t                   active_q [MAX_CHANNELS];
    logic                   tick;
    logic                   pulsing;
    logic                   upd_fire;

    // The µs grid is re-phased at every LATCH, so all pulse edges sit on
    // whole-µs offsets from frame_start.
    us_tick_gen #(
        .CLK_MHZ (CLK_MHZ)
    ) u_tick (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .restart (state_q == ST_LATCH),
        .tick    (tick)
    );

    // LATCH is also µs cycle 0 of channel 0: the counters read as zero and
    // the length in force is the shadow value being copied this cycle.
    // That keeps every pulse at exactly len*CLK_MHZ cycles and the frame at
    // exactly FRAME_US*CLK_MHZ cycles.
    always_comb begin
        state_d       = state_q;
        chan_d        = chan_q;
        pulse_cnt_d   = pulse_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        chan_eff      = chan_q;
        pulse_cnt_eff = pulse_cnt_q;
        frame_cnt_eff = frame_cnt_q;
        cur_len       = active_q[chan_q];

        if (state_q == ST_LATCH) begin
            chan_eff      = '0;
            pulse_cnt_eff = '0;
            frame_cnt_eff = '0;
            cur_len       = shadow_q[0];
        end

        unique case (state_q)
            ST_LATCH, ST_PULSE: begin
                state_d     = ST_PULSE;
                chan_d      = chan_eff;
                pulse_cnt_d = pulse_cnt_eff;
                frame_cnt_d = frame_cnt_eff;
                if (tick) begin
                    frame_cnt_d = frame_cnt_eff + FRAME_CNT_W'(1);
                    if (pulse_cnt_eff + len_t'(1) == cur_len) begin
                        // Next channel rises on the same edge this one falls.
                        pulse_cnt_d = '0;
                        if (chan_eff == LAST_CH) state_d = ST_GAP;
                        else                     chan_d  = chan_eff + 3'd1;
                    end else begin
                        pulse_cnt_d = pulse_cnt_eff + len_t'(1);
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                    if (frame_cnt_q + FRAME_CNT_W'(1) == FRAME_END) state_d = ST_LATCH;
                end
            end
            default: state_d = ST_LATCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= ST_LATCH;
            chan_q      <= '0;
            pulse_cnt_q <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            chan_q      <= chan_d;
            pulse_cnt_q <= pulse_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign upd_fire = upd_valid && upd_ready;

    // Out-of-range channels complete the handshake but write nothing.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            // NOTE: these small register files must come out of reset at DEFAULT_US, so they are reset explicitly.
            for (int i = 0; i < MAX_CHANNELS; i++) begin
                shadow_q[i] <= DEF_LEN;
                active_q[i] <= DEF_LEN;
            end
        end else begin
            if (state_q == ST_LATCH) begin
                for (int i = 0; i < MAX_CHANNELS; i++) active_q[i] <= shadow_q[i];
            end
            if (upd_fire && ({1'b0, upd_chan} < NUM_CH)) begin
                shadow_q[upd_chan] <= clamp_len(upd_len, MIN_LEN, MAX_LEN);
            end
        end
    end

    // Outputs are gated by RST_N so they read idle for the whole reset.
    always_comb begin
        pulsing      = RST_N && (state_q != ST_GAP);
        frame_start  = RST_N && (state_q == ST_LATCH);
        upd_ready    = RST_N && (state_q != ST_LATCH);
        active_chan  = pulsing ? chan_eff : 3'd0;
        CONTROL_PINS = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            CONTROL_PINS[i] = pulsing && (chan_eff == 3'(i));
        end
    end

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_servo_frame_scheduler
//   Directed bench for servo_frame_scheduler with CLK_MHZ=2, FRAME_US=10000,
//   CHANNELS=4 (frame = 20000 cycles, 1 µs = 2 cycles).
// -----------------------------------------------------------------------------
module tb_servo_frame_scheduler;

    localparam int CHANNELS  = 4;
    localparam int FRAME_CYC = 20000;
    localparam int MEAS_CAP  = FRAME_CYC + 5000;

    logic                CLK = 1'b0;
    logic                RST_N = 1'b0;
    logic                upd_valid = 1'b0;
    logic [2:0]          upd_chan = 3'd0;
    logic [15:0]         upd_len = 16'd0;
    logic                upd_ready;
    logic [CHANNELS-1:0] CONTROL_PINS;
    logic                frame_start;
    logic [2:0]          active_chan;

    int tests_run    = 0;
    int tests_failed = 0;

    int meas_hi [CHANNELS];
    int meas_gap;
    int meas_period;
    bit meas_seq_ok;
    int upd_wait;
    bit upd_ok;

    servo_frame_scheduler #(
        .CHANNELS   (CHANNELS),
        .CLK_MHZ    (2),
        .FRAME_US   (10000),
        .MIN_US     (1000),
        .MAX_US     (2000),
        .DEFAULT_US (1500)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_chan     (upd_chan),
        .upd_len      (upd_len),
        .CONTROL_PINS (CONTROL_PINS),
        .frame_start  (frame_start),
        .active_chan  (active_chan)
    );

    always #5 CLK = ~CLK;

    // Called at a negedge where frame_start is high. Samples every cycle until
    // the next frame_start or max_cycles; records per-pin high time, idle
    // time, period, and whether pins formed one contiguous 0..N-1 train.
    task automatic measure_frame(input int max_cycles);
        int n = 0;
        int prev = -1;
        int idx = 0;
        bit in_tail = 1'b0;
        for (int i = 0; i < CHANNELS; i++) meas_hi[i] = 0;
        meas_gap    = 0;
        meas_seq_ok = 1'b1;
        meas_period = -1;
        forever begin
            if (CONTROL_PINS == '0) begin
                meas_gap++;
                if (prev >= 0 && prev < CHANNELS - 1) meas_seq_ok = 1'b0;
                if (prev == CHANNELS - 1) in_tail = 1'b1;
            end else if (!$onehot(CONTROL_PINS) || in_tail) begin
                meas_seq_ok = 1'b0;
            end else begin
                for (int i = 0; i < CHANNELS; i++) if (CONTROL_PINS[i]) idx = i;
                if (idx != prev && idx != prev + 1) meas_seq_ok = 1'b0;
                if (active_chan != 3'(idx)) meas_seq_ok = 1'b0;
                meas_hi[idx]++;
                prev = idx;
            end
            n++;
            @(negedge CLK);
            if (frame_start) begin meas_period = n; break; end
            if (n >= max_cycles) begin meas_period = n; break; end
            if (n >= MEAS_CAP) begin meas_period = -1; break; end
        end
    endtask

    // Called at a negedge; holds valid until accepted (bounded).
    task automatic send_update(input logic [2:0] ch, input logic [15:0] len);
        upd_chan  = ch;
        upd_len   = len;
        upd_valid = 1'b1;
        upd_wait  = 0;
        while (!upd_ready && upd_wait < 50) begin
            @(negedge CLK);
            upd_wait++;
        end
        upd_ok = upd_ready;
        @(negedge CLK);
        upd_valid = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        tests_run++;
        if (CONTROL_PINS !== 4'b0000) begin tests_failed++; $display("FAIL reset_pins: got %b expected 0000", CONTROL_PINS); end
        tests_run++;
        if (frame_start !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
        tests_run++;
        if (upd_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_upd_ready: got %b expected 0", upd_ready); end
        tests_run++;
        if (active_chan !== 3'd0) begin tests_failed++; $display("FAIL reset_active_chan: got %0d expected 0", active_chan); end
        RST_N = 1'b1;
        #1;
        tests_run++;
        if (frame_start !== 1'b1) begin tests_failed++; $display("FAIL release_frame_start: got %b expected 1", frame_start); end
        tests_run++;
        if (upd_ready !== 1'b0) begin tests_failed++; $display("FAIL latch_upd_ready: got %b expected 0", upd_ready); end
    endtask

    // Frame 1: defaults; updates posted mid-frame must not touch this frame.
    task automatic test_frame_with_updates();
        int exp_hi [CHANNELS] = '{3000, 3000, 3000, 3000};
        fork
            measure_frame(MEAS_CAP);
            begin
                repeat (1000) @(negedge CLK);
                send_update(3'd1, 16'd1200);
                tests_run++;
                if (!upd_ok || upd_wait != 0) begin tests_failed++; $display("FAIL upd_ch1_handshake: got ok=%0b wait=%0d expected ok=1 wait=0", upd_ok, upd_wait); end
                repeat (4000) @(negedge CLK);
                send_update(3'd2, 16'd500);
                tests_run++;
                if (!upd_ok || upd_wait != 0) begin tests_failed++; $display("FAIL upd_ch2_handshake: got ok=%0b wait=%0d expected ok=1 wait=0", upd_ok, upd_wait); end
                repeat (4000) @(negedge CLK);
                send_update(3'd3, 16'd2500);
                tests_run++;
                if (!upd_ok || upd_wait != 0) begin tests_failed++; $display("FAIL upd_ch3_handshake: got ok=%0b wait=%0d expected ok=1 wait=0", upd_ok, upd_wait); end
            end
        join
        for (int i = 0; i < CHANNELS; i++) begin
            tests_run++;
            if (meas_hi[i] != exp_hi[i]) begin tests_failed++; $display("FAIL f1_pin%0d_high: got %0d expected %0d", i, meas_hi[i], exp_hi[i]); end
        end
        tests_run++;
        if (meas_gap != 8000) begin tests_failed++; $display("FAIL f1_gap: got %0d expected 8000", meas_gap); end
        tests_run++;
        if (meas_period != FRAME_CYC) begin tests_failed++; $display("FAIL f1_period: got %0d expected %0d", meas_period, FRAME_CYC); end
        tests_run++;
        if (!meas_seq_ok) begin tests_failed++; $display("FAIL f1_sequence: got broken expected contiguous 0..3"); end
    endtask

    // Frame 2: ch1=1200 and clamped ch2/ch3 take effect. An update held
    // across LATCH completes one cycle later; a bad-channel update is posted.
    task automatic test_shadow_apply();
        int exp_hi [CHANNELS] = '{3000, 2400, 2000, 4000};
        tests_run++;
        if (frame_start !== 1'b1) begin tests_failed++; $display("FAIL f2_start_strobe: got %b expected 1", frame_start); end
        fork
            measure_frame(MEAS_CAP);
            begin
                send_update(3'd0, 16'd1800);
                tests_run++;
                if (!upd_ok || upd_wait != 1) begin tests_failed++; $display("FAIL latch_hold_handshake: got ok=%0b wait=%0d expected ok=1 wait=1", upd_ok, upd_wait); end
                repeat (3000) @(negedge CLK);
                send_update(3'd5, 16'd1000);
                tests_run++;
                if (!upd_ok || upd_wait != 0) begin tests_failed++; $display("FAIL bad_chan_handshake: got ok=%0b wait=%0d expected ok=1 wait=0", upd_ok, upd_wait); end
            end
        join
        for (int i = 0; i < CHANNELS; i++) begin
            tests_run++;
            if (meas_hi[i] != exp_hi[i]) begin tests_failed++; $display("FAIL f2_pin%0d_high: got %0d expected %0d", i, meas_hi[i], exp_hi[i]); end
        end
        tests_run++;
        if (meas_gap != 8600) begin tests_failed++; $display("FAIL f2_gap: got %0d expected 8600", meas_gap); end
        tests_run++;
        if (meas_period != FRAME_CYC) begin tests_failed++; $display("FAIL f2_period: got %0d expected %0d", meas_period, FRAME_CYC); end
        tests_run++;
        if (!meas_seq_ok) begin tests_failed++; $display("FAIL f2_sequence: got broken expected contiguous 0..3"); end
    endtask

    // Frame 3 (first 7000 cycles): ch0=1800 µs applied one frame late,
    // bad-channel update changed nothing, ch2 is mid-pulse at the end.
    task automatic test_latch_hold_effect();
        int exp_hi [CHANNELS] = '{3600, 2400, 1000, 0};
        measure_frame(7000);
        for (int i = 0; i < CHANNELS; i++) begin
            tests_run++;
            if (meas_hi[i] != exp_hi[i]) begin tests_failed++; $display("FAIL f3_pin%0d_high: got %0d expected %0d", i, meas_hi[i], exp_hi[i]); end
        end
        tests_run++;
        if (meas_period != 7000 || meas_gap != 0 || !meas_seq_ok) begin tests_failed++; $display("FAIL f3_window: got cycles=%0d gap=%0d seq=%0b expected 7000 0 1", meas_period, meas_gap, meas_seq_ok); end
        tests_run++;
        if (CONTROL_PINS !== 4'b0100 || active_chan !== 3'd2) begin tests_failed++; $display("FAIL f3_mid_ch2: got pins=%b chan=%0d expected 0100 2", CONTROL_PINS, active_chan); end
    endtask

    // One-cycle reset mid ch2: pins drop, frame restarts, defaults return.
    task automatic test_reset_mid_pulse();
        int exp_hi [CHANNELS] = '{3000, 3000, 3000, 3000};
        RST_N = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (CONTROL_PINS !== 4'b0000) begin tests_failed++; $display("FAIL midreset_pins: got %b expected 0000", CONTROL_PINS); end
        tests_run++;
        if (frame_start !== 1'b0 || upd_ready !== 1'b0 || active_chan !== 3'd0) begin tests_failed++; $display("FAIL midreset_outputs: got fs=%b rdy=%b chan=%0d expected 0 0 0", frame_start, upd_ready, active_chan); end
        RST_N = 1'b1;
        #1;
        tests_run++;
        if (frame_start !== 1'b1) begin tests_failed++; $display("FAIL midreset_restart: got %b expected 1", frame_start); end
        measure_frame(MEAS_CAP);
        for (int i = 0; i < CHANNELS; i++) begin
            tests_run++;
            if (meas_hi[i] != exp_hi[i]) begin tests_failed++; $display("FAIL f4_pin%0d_high: got %0d expected %0d", i, meas_hi[i], exp_hi[i]); end
        end
        tests_run++;
        if (meas_gap != 8000) begin tests_failed++; $display("FAIL f4_gap: got %0d expected 8000", meas_gap); end
        tests_run++;
        if (meas_period != FRAME_CYC) begin tests_failed++; $display("FAIL f4_period: got %0d expected %0d", meas_period, FRAME_CYC); end
        tests_run++;
        if (!meas_seq_ok) begin tests_failed++; $display("FAIL f4_sequence: got broken expected contiguous 0..3"); end
    endtask

    initial begin
        test_reset();
        test_frame_with_updates();
        test_shadow_apply();
        test_latch_hold_effect();
        test_reset_mid_pulse();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
